// File: rtl/ps2_letter_buffer.sv
// PS/2 set-2 receiver feeding a three-slot uppercase letter buffer.
// Slots drive the VGA text controller directly in the clk domain.
`timescale 1ns/1ps
module ps2_letter_buffer #(
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] BLANK_CHAR     = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] letter_sel_one,
    output logic [7:0] letter_sel_two,
    output logic [7:0] letter_sel_three,
    output logic [1:0] letter_count,
    output logic       word_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE, S_DATA, S_PARITY, S_STOP
    } rx_state_t;

    rx_state_t state, state_nxt;

    logic [1:0]    clk_pipe, dat_pipe;
    logic          clk_sync, dat_sync, clk_filt;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] to_cnt;
    logic          sample, timeout;
    logic [7:0]    shift, code;
    logic [2:0]    bit_cnt;
    logic          par_bit, code_valid;
    logic          shift_en, par_en, frame_ok, frame_bad;
    logic          brk, ext;
    logic [7:0]    slot [3];
    logic [1:0]    cnt;
    logic          is_letter, is_bksp, is_esc, is_enter;
    logic [7:0]    ascii;

    assign clk_sync = clk_pipe[1];
    assign dat_sync = dat_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_pipe <= 2'b11;
            dat_pipe <= 2'b11;
        end else begin
            clk_pipe <= {clk_pipe[0], ps2_clk};
            dat_pipe <= {dat_pipe[0], ps2_data};
        end
    end

    // New level is taken once it has differed for FILTER_LEN cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else if (clk_sync == clk_filt) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync;
            flt_cnt  <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign sample = clk_filt && !clk_sync
                    && (flt_cnt == FW'(FILTER_LEN - 1));
    assign timeout = (state != S_IDLE) && !sample
                     && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_IDLE;
        end else if (sample) begin
            unique case (state)
                S_IDLE:   if (!dat_sync) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en  = sample && (state == S_DATA);
        par_en    = sample && (state == S_PARITY);
        frame_ok  = sample && (state == S_STOP) && dat_sync
                    && (^{shift, par_bit});
        frame_bad = timeout
                    || (sample && (state == S_STOP) && !frame_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (state == S_IDLE)  bit_cnt <= '0;
            else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift   <= {dat_sync, shift[7:1]};
            if (par_en)   par_bit <= dat_sync;
            if (state == S_IDLE || sample) to_cnt <= '0;
            else                           to_cnt <= to_cnt + 1'b1;
            if (frame_ok) code <= shift;
            code_valid <= frame_ok;
            frame_err  <= frame_bad;
        end
    end

    always_comb begin
        is_letter = 1'b1;
        ascii     = BLANK_CHAR;
        case (code)
            8'h1C: ascii = 8'h41;  8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;  8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;  8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;  8'h33: ascii = 8'h48;
            8'h43: ascii = 8'h49;  8'h3B: ascii = 8'h4A;
            8'h42: ascii = 8'h4B;  8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;  8'h31: ascii = 8'h4E;
            8'h44: ascii = 8'h4F;  8'h4D: ascii = 8'h50;
            8'h15: ascii = 8'h51;  8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;  8'h2C: ascii = 8'h54;
            8'h3C: ascii = 8'h55;  8'h2A: ascii = 8'h56;
            8'h1D: ascii = 8'h57;  8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;  8'h1A: ascii = 8'h5A;
            default: is_letter = 1'b0;
        endcase
        is_bksp  = (code == 8'h66);
        is_esc   = (code == 8'h76);
        is_enter = (code == 8'h5A);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk        <= 1'b0;
            ext        <= 1'b0;
            cnt        <= '0;
            word_valid <= 1'b0;
            for (int i = 0; i < 3; i++) slot[i] <= BLANK_CHAR;
        end else begin
            word_valid <= 1'b0;
            if (code_valid) begin
                if (code == 8'hF0) begin
                    brk <= 1'b1;
                end else if (code == 8'hE0) begin
                    ext <= 1'b1;
                end else if (brk || ext) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else begin
                    unique case (1'b1)
                        is_letter: if (cnt != 2'd3) begin
                            for (int i = 0; i < 3; i++)
                                if (cnt == 2'(i)) slot[i] <= ascii;
                            cnt <= cnt + 2'd1;
                        end
                        is_bksp: if (cnt != 2'd0) begin
                            for (int i = 0; i < 3; i++)
                                if (cnt - 2'd1 == 2'(i)) slot[i] <= BLANK_CHAR;
                            cnt <= cnt - 2'd1;
                        end
                        is_esc: begin
                            for (int i = 0; i < 3; i++) slot[i] <= BLANK_CHAR;
                            cnt <= '0;
                        end
                        is_enter: word_valid <= (cnt == 2'd3);
                        default: ;
                    endcase
                end
            end
        end
    end

    assign letter_sel_one   = slot[0];
    assign letter_sel_two   = slot[1];
    assign letter_sel_three = slot[2];
    assign letter_count     = cnt;

endmodule

// File: tb/tb_ps2_letter_buffer.sv
// Directed plus randomized bench for ps2_letter_buffer against a
// queue-based model of the letter buffer.
`timescale 1ns/1ps
module tb_ps2_letter_buffer;

    localparam int TO = 2000;
    localparam int H  = 20;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data;
    logic [7:0] l1, l2, l3;
    logic [1:0] lcnt;
    logic       word_valid, frame_err;

    ps2_letter_buffer #(
        .FILTER_LEN(8), .TIMEOUT_CYCLES(TO), .BLANK_CHAR(8'h20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .letter_sel_one(l1), .letter_sel_two(l2),
        .letter_sel_three(l3), .letter_count(lcnt),
        .word_valid(word_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wv_seen = 0;
    int fe_seen = 0;
    int exp_wv = 0;
    int exp_fe = 0;

    logic [7:0] q[$];
    bit         brk, ext;
    logic [7:0] codes [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
        8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
        8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    always @(negedge clk) begin
        if (word_valid) wv_seen++;
        if (frame_err)  fe_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_slot(input int i);
        return (i < q.size()) ? q[i] : 8'h20;
    endfunction

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, ".slot0"}, 32'(l1), 32'(exp_slot(0)));
        chk({tag, ".slot1"}, 32'(l2), 32'(exp_slot(1)));
        chk({tag, ".slot2"}, 32'(l3), 32'(exp_slot(2)));
        chk({tag, ".count"}, 32'(lcnt), 32'(q.size()));
        chk({tag, ".word_valid"}, 32'(wv_seen), 32'(exp_wv));
        chk({tag, ".frame_err"}, 32'(fe_seen), 32'(exp_fe));
    endtask

    function automatic void model_code(input logic [7:0] c);
        int idx = -1;
        for (int i = 0; i < 26; i++) if (codes[i] == c) idx = i;
        if (c == 8'hF0) brk = 1;
        else if (c == 8'hE0) ext = 1;
        else if (brk || ext) begin brk = 0; ext = 0; end
        else if (idx >= 0) begin
            if (q.size() < 3) q.push_back(8'h41 + 8'(idx));
        end
        else if (c == 8'h66) begin
            if (q.size() > 0) void'(q.pop_back());
        end
        else if (c == 8'h76) q.delete();
        else if (c == 8'h5A && q.size() == 3) exp_wv++;
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input logic stop_bit, input int nbits);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H / 2) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (H / 2) @(posedge clk);
        end
        ps2_data = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    task automatic send_code(input logic [7:0] c);
        send_frame(c, 1'b0, 1'b1, 11);
        model_code(c);
    endtask

    initial begin
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        brk = 0; ext = 0;
        repeat (5) @(posedge clk);
        check_state("reset");
        @(negedge clk) rst_n = 1'b1;

        send_code(8'h15);
        check_state("make_Q");
        send_code(8'hF0); send_code(8'h15);
        check_state("break_Q");

        send_code(8'h76);
        check_state("esc");
        send_code(8'h43); send_code(8'h1C); send_code(8'h2C);
        check_state("IAT");
        send_code(8'h3C);
        check_state("fourth_dropped");
        send_code(8'h5A);
        check_state("enter");

        send_code(8'h66); send_code(8'h66);
        check_state("bksp2");
        send_code(8'h66); send_code(8'h66);
        check_state("bksp_underflow");

        send_code(8'h32);
        send_frame(8'h1C, 1'b1, 1'b1, 11); exp_fe++;
        check_state("parity_err");
        send_frame(8'h1C, 1'b0, 1'b0, 11); exp_fe++;
        check_state("stop_err");

        send_frame(8'h1C, 1'b0, 1'b1, 5);
        repeat (TO + 20) @(posedge clk);
        exp_fe++;
        check_state("timeout");
        send_code(8'h32);
        check_state("after_timeout");

        send_code(8'hE0); send_code(8'h75);
        send_code(8'hE0); send_code(8'hF0); send_code(8'h75);
        check_state("extended");

        ps2_data = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ps2_clk = 1'b0; #1; ps2_clk = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            ps2_clk = 1'b0;
            repeat ($urandom_range(1, 5)) @(posedge clk);
            ps2_clk = 1'b1;
            repeat ($urandom_range(12, 20)) @(posedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
        send_code(8'h4D);
        check_state("glitch");

        for (int n = 0; n < 60; n++) begin
            int unsigned r = $urandom_range(0, 11);
            logic [7:0] c;
            unique case (r)
                0, 1, 2, 3, 4: c = codes[$urandom_range(0, 25)];
                5:  c = 8'hF0;
                6:  c = 8'hE0;
                7:  c = 8'h66;
                8:  c = 8'h5A;
                9:  c = 8'h76;
                10: c = 8'($urandom);
                default: c = 8'h5A;
            endcase
            if (r == 11) begin
                send_frame(codes[$urandom_range(0, 25)], 1'b1, 1'b1, 11);
                exp_fe++;
            end else begin
                send_code(c);
            end
            check_state("random");
        end

        send_code(8'h76); send_code(8'h1A);
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        rst_n = 1'b0;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        #1;
        q.delete(); brk = 0; ext = 0;
        chk("midreset.slot0", 32'(l1), 32'h20);
        chk("midreset.count", 32'(lcnt), 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        send_code(8'h35);
        check_state("after_reset");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_letter_buffer.md
Name: ps2_letter_buffer

Overview:
- Receives a PS/2 keyboard stream (scan code set 2) and decodes key presses.
- Holds up to three uppercase ASCII letters, filled left to right.
- Drives letter_sel_one/two/three directly into the VGA text controller, in the same clk domain.
- Supports backspace, clear (Esc) and a word-commit pulse (Enter).

Parameters:
- FILTER_LEN, 8: clk cycles ps2_clk must be stable before a level change is accepted.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge mid-frame before the frame is aborted.
- BLANK_CHAR, 8'h20: ASCII value driven for an empty slot.

Ports:
- clk  input  1  system/pixel clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw keyboard clock, asynchronous.
- ps2_data  input  1  raw keyboard data, asynchronous.
- letter_sel_one  output  8  ASCII for slot 0 (leftmost).
- letter_sel_two  output  8  ASCII for slot 1.
- letter_sel_three  output  8  ASCII for slot 2.
- letter_count  output  2  number of filled slots, 0..3.
- word_valid  output  1  one-cycle pulse: Enter pressed with 3 letters held.
- frame_err  output  1  one-cycle pulse: parity or stop-bit error, or timeout.

Behaviour:
- Reset (async assert, sync release):
  - All slots = BLANK_CHAR; letter_count = 0; word_valid = 0; frame_err = 0.
  - Receiver in IDLE; break and ext flags cleared.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - ps2_clk then passes a FILTER_LEN stability counter.
  - A falling edge of the filtered clock = one sample event; ps2_data is sampled on it.
- Receiver FSM, IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: on a sample event with data 0 (start bit), go to DATA with bit_cnt = 0. A sample with data 1 is ignored.
  - DATA: shift in 8 bits, LSB first; after bit 7 go to PARITY.
  - PARITY: store the bit. The 9 bits (data + parity) must contain an odd number of ones.
  - STOP: the bit must be 1.
    - Pass: code_valid pulses internally on the cycle after the stop sample.
    - Parity fail or stop = 0: frame_err pulses on that same cycle and the byte is discarded.
    - Either way, return to IDLE.
  - Timeout: in any non-IDLE state, a TIMEOUT_CYCLES counter reloads on each sample event. On expiry: pulse frame_err, return to IDLE, discard partial byte.
- Decoder (acts on code_valid):
  - 0xF0: set break flag.
  - 0xE0: set ext flag.
  - Any other code with break or ext set: discarded, both flags cleared (ignores releases and extended keys).
  - Otherwise a make code:
    - Letter codes: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F, 34=G, 33=H, 43=I, 3B=J, 42=K, 4B=L, 3A=M, 31=N, 44=O, 4D=P, 15=Q, 2D=R, 1B=S, 2C=T, 3C=U, 2A=V, 1D=W, 22=X, 35=Y, 1A=Z. Output ASCII is 0x41..0x5A.
    - Backspace 0x66, Enter 0x5A, Esc 0x76.
    - All other codes are ignored.
- Buffer update, registered; visible on the cycle after code_valid:
  - Letter, count < 3: slot[count] <= ASCII; count++.
  - Letter, count == 3: dropped; no change.
  - Backspace, count > 0: slot[count-1] <= BLANK_CHAR; count--.
  - Backspace, count == 0: no-op.
  - Esc: all slots BLANK_CHAR; count 0.
  - Enter, count == 3: word_valid pulses one cycle; slots retained.
  - Enter, count < 3: no pulse.
- Latency: stop-bit sample at cycle N -> code_valid at N+1 -> letter output and letter_count change at N+2.
- Outputs are registered and glitch-free; they change only on the update cycle.
- Reset mid-frame: the partial byte is lost. The first frame after reset must decode normally.

Test Plan:
- Reset, then frame 0x15 (data bits 1,0,1,0,1,0,0,0; parity 0; stop 1), then F0,15 -> letter_sel_one = 0x51; letter_count = 1; release causes no change; other slots 0x20.
- Make codes 43, 1C, 2C, then 3C -> slots 0x49, 0x41, 0x54; count = 3; fourth letter dropped; then Enter (5A) -> exactly one word_valid pulse.
- With 3 letters held, Backspace twice -> slot three and slot two = 0x20, count = 1. Backspace twice more -> count = 0, then no-op; no underflow.
- Frame 0x1C with parity bit flipped -> frame_err pulses one cycle; slots unchanged. Repeat with stop = 0 -> same result.
- Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES + 1 -> frame_err pulses. A following valid 0x32 decodes to 0x42.
- Extended sequence E0,75 then E0,F0,75 -> no change. 1 ns glitches on ps2_clk (< FILTER_LEN) -> no sample events. Assert rst_n low mid-frame -> all slots 0x20 immediately.
